// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS writeback / register-file slice.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] LINK_REG = 5'd31;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // Writeback data source, in increasing priority order.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_DM   = 2'd1,
    WB_MUL  = 2'd2,
    WB_LINK = 2'd3
  } wb_sel_t;

  // Fixed-priority source decode: link beats multiplier beats memory beats ALU.
  function automatic wb_sel_t wb_sel_decode(input logic jalsrc,
                                            input logic muxmul,
                                            input logic dm2reg);
    wb_sel_t sel;
    if (jalsrc) begin
      sel = WB_LINK;
    end else if (muxmul) begin
      sel = WB_MUL;
    end else if (dm2reg) begin
      sel = WB_DM;
    end else begin
      sel = WB_ALU;
    end
    return sel;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB pipeline-register bundle feeding the writeback stage.
interface wb_regfile_if;
  import mips_pkg::*;

  logic              MEM_WB_we_reg;
  logic              MEM_WB_dm2reg;
  logic              MEM_WB_muxmul;
  logic              MEM_WB_jalsrc;
  logic [ADDR_W-1:0] MEM_WB_rf_wa;
  logic [DATA_W-1:0] MEM_WB_alu_pa;
  logic [DATA_W-1:0] MEM_WB_temp_alu;
  logic [DATA_W-1:0] MEM_WB_multi;
  logic [DATA_W-1:0] MEM_WB_rd_dm;

  // The MEM/WB register side drives the bundle.
  modport master (
    output MEM_WB_we_reg, MEM_WB_dm2reg, MEM_WB_muxmul, MEM_WB_jalsrc,
           MEM_WB_rf_wa, MEM_WB_alu_pa, MEM_WB_temp_alu, MEM_WB_multi,
           MEM_WB_rd_dm
  );

  // The writeback stage consumes it.
  modport slave (
    input  MEM_WB_we_reg, MEM_WB_dm2reg, MEM_WB_muxmul, MEM_WB_jalsrc,
           MEM_WB_rf_wa, MEM_WB_alu_pa, MEM_WB_temp_alu, MEM_WB_multi,
           MEM_WB_rd_dm
  );

endinterface

// File: rtl/wb_select.sv
// Writeback source priority mux and link-register address override.
module wb_select
  import mips_pkg::*;
(
  input  logic              jalsrc,
  input  logic              muxmul,
  input  logic              dm2reg,
  input  logic [ADDR_W-1:0] rf_wa,
  input  logic [DATA_W-1:0] alu_pa,
  input  logic [DATA_W-1:0] temp_alu,
  input  logic [DATA_W-1:0] multi,
  input  logic [DATA_W-1:0] rd_dm,
  output logic [DATA_W-1:0] wd_wb,
  output logic [ADDR_W-1:0] wa_wb
);

  wb_sel_t sel_s;

  assign sel_s = wb_sel_decode(jalsrc, muxmul, dm2reg);

  // Pick the writeback data and the destination; jal always links into r31.
  always_comb begin
    wd_wb = alu_pa;
    wa_wb = rf_wa;
    case (sel_s)
      WB_LINK: begin
        wd_wb = temp_alu;
        wa_wb = LINK_REG;
      end
      WB_MUL:  wd_wb = multi;
      WB_DM:   wd_wb = rd_dm;
      WB_ALU:  wd_wb = alu_pa;
      default: wd_wb = alu_pa;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus 32x32 architectural register file and retired-write counter.
// Optional build macro: WB_BYPASS_EN forwards the in-flight writeback onto rd1/rd2.
module wb_regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  wb_regfile_if.slave       mem_wb,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] ra3,
  output logic [DATA_W-1:0] rd3,
  output logic [DATA_W-1:0] wd_wb,
  output logic [ADDR_W-1:0] wa_wb,
  output logic              we_wb,
  output logic [31:0]       wr_count
);

  logic [DATA_W-1:0] regs_r [0:NUM_REGS-1];
  logic [31:0]       wr_count_r;
  logic [DATA_W-1:0] wd_wb_s;
  logic [ADDR_W-1:0] wa_wb_s;
  logic              we_wb_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic [DATA_W-1:0] rd3_s;

  wb_select u_wb_select (
    .jalsrc   (mem_wb.MEM_WB_jalsrc),
    .muxmul   (mem_wb.MEM_WB_muxmul),
    .dm2reg   (mem_wb.MEM_WB_dm2reg),
    .rf_wa    (mem_wb.MEM_WB_rf_wa),
    .alu_pa   (mem_wb.MEM_WB_alu_pa),
    .temp_alu (mem_wb.MEM_WB_temp_alu),
    .multi    (mem_wb.MEM_WB_multi),
    .rd_dm    (mem_wb.MEM_WB_rd_dm),
    .wd_wb    (wd_wb_s),
    .wa_wb    (wa_wb_s)
  );

  // Writes to r0 are squashed here so they neither land nor count.
  assign we_wb_s = mem_wb.MEM_WB_we_reg && (wa_wb_s != REG_ZERO);

  // Commit the writeback and count it; reset clears everything without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      wr_count_r <= 32'd0;
    end else if (we_wb_s) begin
      regs_r[wa_wb_s] <= wd_wb_s;
      wr_count_r      <= wr_count_r + 32'd1;
    end
  end

  // Read ports: r0 is hard zero; decode ports optionally see the in-flight write.
  always_comb begin
    rd1_s = (ra1 == REG_ZERO) ? {DATA_W{1'b0}} : regs_r[ra1];
    rd2_s = (ra2 == REG_ZERO) ? {DATA_W{1'b0}} : regs_r[ra2];
    rd3_s = (ra3 == REG_ZERO) ? {DATA_W{1'b0}} : regs_r[ra3];
`ifdef WB_BYPASS_EN
    // we_wb_s already excludes r0, so r0 reads never pick up the bypass.
    if (we_wb_s && (ra1 == wa_wb_s)) begin
      rd1_s = wd_wb_s;
    end else begin
      rd1_s = rd1_s;
    end
    if (we_wb_s && (ra2 == wa_wb_s)) begin
      rd2_s = wd_wb_s;
    end else begin
      rd2_s = rd2_s;
    end
`endif
  end

  assign rd1      = rd1_s;
  assign rd2      = rd2_s;
  assign rd3      = rd3_s;
  assign wd_wb    = wd_wb_s;
  assign wa_wb    = wa_wb_s;
  assign we_wb    = we_wb_s;
  assign wr_count = wr_count_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed, scoreboard-checked bench for wb_regfile.
module tb_wb_regfile;
  import mips_pkg::*;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] ra1, ra2, ra3;
  logic [DATA_W-1:0] rd1, rd2, rd3;
  logic [DATA_W-1:0] wd_wb;
  logic [ADDR_W-1:0] wa_wb;
  logic              we_wb;
  logic [31:0]       wr_count;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .mem_wb   (bus.slave),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .ra3      (ra3),
    .rd3      (rd3),
    .wd_wb    (wd_wb),
    .wa_wb    (wa_wb),
    .we_wb    (we_wb),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_regs [0:31];
  logic [31:0] model_count;
  logic [31:0] exp_wd;
  logic [4:0]  exp_wa;
  logic        exp_we;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.MEM_WB_we_reg   = 1'b0;
    bus.MEM_WB_dm2reg   = 1'b0;
    bus.MEM_WB_muxmul   = 1'b0;
    bus.MEM_WB_jalsrc   = 1'b0;
    bus.MEM_WB_rf_wa    = 5'd0;
    bus.MEM_WB_alu_pa   = 32'd0;
    bus.MEM_WB_temp_alu = 32'd0;
    bus.MEM_WB_multi    = 32'd0;
    bus.MEM_WB_rd_dm    = 32'd0;
  endtask

  // Present one MEM/WB word (at a negedge), check the combinational outputs, queue the expected commit.
  task automatic drive(input logic we, input logic dm, input logic mul, input logic jal,
                       input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] tmp,
                       input logic [31:0] mu, input logic [31:0] rdm, input string tag);
    exp_t e;
    bus.MEM_WB_we_reg   = we;
    bus.MEM_WB_dm2reg   = dm;
    bus.MEM_WB_muxmul   = mul;
    bus.MEM_WB_jalsrc   = jal;
    bus.MEM_WB_rf_wa    = wa;
    bus.MEM_WB_alu_pa   = alu;
    bus.MEM_WB_temp_alu = tmp;
    bus.MEM_WB_multi    = mu;
    bus.MEM_WB_rd_dm    = rdm;
    if (jal)      exp_wd = tmp;
    else if (mul) exp_wd = mu;
    else if (dm)  exp_wd = rdm;
    else          exp_wd = alu;
    exp_wa = jal ? 5'd31 : wa;
    exp_we = we && (exp_wa != 5'd0);
    #1;
    chk({tag, "_wd"}, wd_wb, exp_wd);
    chk({tag, "_wa"}, {27'd0, wa_wb}, {27'd0, exp_wa});
    chk({tag, "_we"}, {31'd0, we_wb}, {31'd0, exp_we});
    if (exp_we) begin
      e.a = exp_wa;
      e.d = exp_wd;
      sb.push_back(e);
    end
  endtask

  // Clock the presented word in, then drain the scoreboard through the debug port.
  task automatic commit(input string tag);
    exp_t e;
    @(posedge clk);
    if (exp_we) begin
      model_regs[exp_wa] = exp_wd;
      model_count = model_count + 32'd1;
    end
    @(negedge clk);
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ra3 = e.a;
      #1;
      chk({tag, "_rd3"}, rd3, e.d);
    end
    chk({tag, "_count"}, wr_count, model_count);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_count = 32'd0;
    sb.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_model();
    idle();
    ra1 = 5'd0; ra2 = 5'd0; ra3 = 5'd0;
    exp_we = 1'b0; exp_wa = 5'd0; exp_wd = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ra1 = 5'd8; ra2 = 5'd31; ra3 = 5'd5;
    #1;
    chk("reset_rd1", rd1, 32'd0);
    chk("reset_rd2", rd2, 32'd0);
    chk("reset_rd3", rd3, 32'd0);
    chk("reset_count", wr_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ALU writeback to r8
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, "alu");
    commit("alu");
    ra1 = 5'd8;
    #1;
    chk("alu_rd1", rd1, 32'hDEADBEEF);
    chk("alu_count1", wr_count, 32'd1);

    // memory-only source
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h99, 32'h0, 32'h0, 32'h22, "dm");
    commit("dm");

    // multiplier beats memory
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h99, 32'h0, 32'h11, 32'h22, "mul");
    commit("mul");

    // link beats everything and overrides the destination with r31
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h99, 32'h400008, 32'h11, 32'h22, "jal");
    commit("jal");
    ra2 = 5'd3;
    ra1 = 5'd31;
    #1;
    chk("jal_r3_unchanged", rd2, model_regs[3]);
    chk("jal_r31", rd1, 32'h400008);

    // write to r0 is dropped and not counted
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF, 32'h0, 32'h0, 32'h0, "zero");
    commit("zero");
    ra2 = 5'd0;
    #1;
    chk("zero_rd2", rd2, 32'd0);

    // we_reg low: nothing lands
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h5A5A, 32'h0, 32'h0, 32'h0, "nowe");
    commit("nowe");
    ra3 = 5'd10;
    #1;
    chk("nowe_r10", rd3, 32'd0);

    // bypass: old r9 value, then an in-flight write with ra1 == 9
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h1111, 32'h0, 32'h0, 32'h0, "old9");
    commit("old9");
    ra1 = 5'd9;
    ra3 = 5'd9;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'hCAFE, 32'h0, 32'h0, 32'h0, "byp");
`ifdef WB_BYPASS_EN
    chk("byp_rd1_same", rd1, 32'hCAFE);
`else
    chk("byp_rd1_same", rd1, 32'h1111);
`endif
    chk("byp_rd3_same", rd3, 32'h1111);
    commit("byp");
    ra1 = 5'd9;
    #1;
    chk("byp_rd1_next", rd1, 32'hCAFE);

    // asynchronous reset mid-run; the write presented alongside is lost
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, "r5");
    commit("r5");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77, 32'h0, 32'h0, 32'h0, "lost");
    ra3 = 5'd5;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rd3", rd3, 32'd0);
    chk("arst_count", wr_count, 32'd0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
    ra3 = 5'd7;
    #1;
    chk("arst_r7_lost", rd3, 32'd0);
    @(negedge clk);

    // first write after reset release is accepted
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'hA5, 32'h0, 32'h0, 32'h0, "post");
    commit("post");

    // counter wrap
    force dut.wr_count_r = 32'hFFFFFFFF;
    #1;
    release dut.wr_count_r;
    #1;
    chk("wrap_preset", wr_count, 32'hFFFFFFFF);
    model_count = 32'hFFFFFFFF;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'h5, 32'h0, 32'h0, 32'h0, "wrap");
    commit("wrap");
    chk("wrap_zero", wr_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
